// File: rtl/dnoc_pkg.sv
// rtl/dnoc_pkg.sv - shared types for the dNoC injection-port arbiter (optional counters: DNOC_ARB_STAT_EN)
package dnoc_pkg;

    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_LOCK = 1'b1;

    typedef enum logic {
        ST_IDLE = ARB_IDLE,
        ST_LOCK = ARB_LOCK
    } arb_state_e;

    typedef logic [255:0] flit_t;

endpackage

// File: rtl/dnoc_flit_skid.sv
// rtl/dnoc_flit_skid.sv - 2-entry valid/ready skid buffer with registered output and registered ready
module dnoc_flit_skid #(
    parameter int W = 257
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    // head drives the output directly; tail only fills while the head is stalled
    logic [W-1:0] head_q, tail_q, head_d, tail_d;
    logic         head_vld_q, tail_vld_q, head_vld_d, tail_vld_d;
    logic         can_acc_q;
    logic         push, pop;

    assign push     = s_tvalid & can_acc_q;
    assign pop      = head_vld_q & m_tready;
    assign s_tready = can_acc_q;
    assign m_tdata  = head_q;
    assign m_tvalid = head_vld_q;

    // next contents: a push never coincides with a full tail, so nothing can be dropped
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        if (pop) begin
            if (tail_vld_q) begin
                head_d     = tail_q;
                tail_vld_d = 1'b0;
            end else if (push) begin
                head_d = s_tdata;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (push) begin
            if (head_vld_q) begin
                tail_d     = s_tdata;
                tail_vld_d = 1'b1;
            end else begin
                head_d     = s_tdata;
                head_vld_d = 1'b1;
            end
        end
    end

    // entry registers; ready is precomputed so upstream sees a flop, not a path through m_tready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            can_acc_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            can_acc_q  <= ~tail_vld_d;
        end
    end

endmodule

// File: rtl/dnoc_itf_out_arb.sv
// rtl/dnoc_itf_out_arb.sv - packet-level round-robin arbiter onto the dNoC injection port (DNOC_ARB_STAT_EN adds per-source packet counters)
module dnoc_itf_out_arb
    import dnoc_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int FLIT_W  = 256,
    parameter int CNT_W   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0][FLIT_W-1:0]    req_flit,
    input  logic [NUM_REQ-1:0]                req_last,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [FLIT_W-1:0]                 out_flit,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              lock_busy,
    output logic [$clog2(NUM_REQ)-1:0]        lock_id
`ifdef DNOC_ARB_STAT_EN
    ,
    output logic [NUM_REQ-1:0][CNT_W-1:0]     pkt_cnt,
    input  logic                              stat_clr
`endif
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_e       state_q;
    logic [IDW-1:0]   ptr_q, pick_id, grant_id;
    logic             pick_found, grant_vld, grant_last, accept;
    logic             skid_can_accept;
    logic [FLIT_W:0]  skid_out;

    // first valid source after ptr, wrapping; MSB of the result flags that one was found
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] vld, input logic [IDW-1:0] ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (vld[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    assign {pick_found, pick_id} = rr_pick(req_valid, ptr_q);
    assign grant_id   = (state_q == ST_LOCK) ? lock_id : pick_id;
    assign grant_vld  = (state_q == ST_LOCK) ? req_valid[lock_id] : pick_found;
    assign grant_last = req_last[grant_id];
    assign accept     = grant_vld & skid_can_accept;

    // only the granted source sees ready, and only when its flit actually transfers
    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_id] = 1'b1;
    end

    // packet lock: ptr moves only on a last flit so every source gets whole packets in turn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDW'(NUM_REQ - 1);
            lock_busy <= 1'b0;
            lock_id   <= '0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_last) begin
                        ptr_q <= pick_id;
                    end else begin
                        state_q   <= ST_LOCK;
                        lock_id   <= pick_id;
                        lock_busy <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (grant_last) begin
                        state_q   <= ST_IDLE;
                        ptr_q     <= lock_id;
                        lock_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    dnoc_flit_skid #(
        .W (FLIT_W + 1)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  ({grant_last, req_flit[grant_id]}),
        .s_tvalid (grant_vld),
        .s_tready (skid_can_accept),
        .m_tdata  (skid_out),
        .m_tvalid (out_valid),
        .m_tready (out_ready)
    );

    assign {out_last, out_flit} = skid_out;

`ifdef DNOC_ARB_STAT_EN
    // packets sent per source; a clear in the same cycle as an increment wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (stat_clr) begin
            pkt_cnt <= '0;
        end else if (accept && grant_last) begin
            pkt_cnt[grant_id] <= pkt_cnt[grant_id] + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dnoc_itf_out_arb.sv
// tb/tb_dnoc_itf_out_arb.sv - randomized bench for dnoc_itf_out_arb against a queue-based reference model
module tb_dnoc_itf_out_arb;

    localparam int N  = 3;
    localparam int FW = 256;
    localparam int CW = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0][FW-1:0] req_flit = '0;
    logic [N-1:0]        req_last = '0;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0]        req_ready;
    logic [FW-1:0]       out_flit;
    logic                out_last, out_valid;
    logic                out_ready = 1'b1;
    logic                lock_busy;
    logic [1:0]          lock_id;
`ifdef DNOC_ARB_STAT_EN
    logic [N-1:0][CW-1:0] pkt_cnt;
    logic                 stat_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    dnoc_itf_out_arb #(.NUM_REQ(N), .FLIT_W(FW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_flit  (req_flit),
        .req_last  (req_last),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lock_busy (lock_busy),
        .lock_id   (lock_id)
`ifdef DNOC_ARB_STAT_EN
        ,
        .pkt_cnt   (pkt_cnt),
        .stat_clr  (stat_clr)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // source-side state: per-source flit queues, each flit {last, data}; data[7:0]=src, data[23:8]=seq
    logic [FW:0] sq [N][$];
    int          seq_ctr [N];
    int          tot_flits;
    int          acc_tot;
    bit          gap_en;
    bit          rdy_mode;

    // reference model: skid contents as a queue, rr pointer and lock as plain ints
    logic [FW:0]  mq [$];
    int           m_ptr, m_owner, m_g;
    bit           m_locked, m_ok;
    logic [N-1:0] m_rdy;
    logic [N-1:0][CW-1:0] m_cnt;
    logic [23:0]  seen [$];
    int           seen_cyc [$];
    int           cyc_n = 0;
    int           busy_n;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ptr = N - 1; m_owner = 0; m_locked = 0; m_ok = 0; m_cnt = '0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_flit", out_flit, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_lock_busy", lock_busy, 0);
            chk("rst_lock_id", lock_id, 0);
`ifdef DNOC_ARB_STAT_EN
            chk("rst_pkt_cnt", pkt_cnt, 0);
`endif
        end else begin
            m_g = -1;
            if (m_ok) begin
                if (m_locked) begin
                    if (req_valid[m_owner]) m_g = m_owner;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                    end
                end
            end
            m_rdy = '0;
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            chk("req_ready", req_ready, m_rdy);
            chk("out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("out_flit", out_flit, mq[0][FW-1:0]);
                chk("out_last", out_last, mq[0][FW]);
            end
            chk("lock_busy", lock_busy, m_locked);
            chk("lock_id", lock_id, m_owner);
`ifdef DNOC_ARB_STAT_EN
            chk("pkt_cnt", pkt_cnt, m_cnt);
`endif
            if (lock_busy) busy_n++;
            if (out_valid && out_ready) begin
                seen.push_back(out_flit[23:0]);
                seen_cyc.push_back(cyc_n);
            end
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (m_g >= 0) begin
                mq.push_back({req_last[m_g], req_flit[m_g]});
                if (req_last[m_g]) begin
                    m_locked = 0;
                    m_ptr = m_g;
                end else begin
                    m_locked = 1;
                    m_owner = m_g;
                end
            end
`ifdef DNOC_ARB_STAT_EN
            if (stat_clr) m_cnt = '0;
            else if (m_g >= 0 && req_last[m_g]) m_cnt[m_g] = m_cnt[m_g] + 1'b1;
`endif
            m_ok = mq.size() < 2;
        end
        cyc_n++;
    end

    task automatic add_pkt(input int src, input int len);
        logic [FW:0] f;
        for (int j = 0; j < len; j++) begin
            for (int w = 0; w < FW / 32; w++) f[w*32 +: 32] = $urandom();
            f[7:0]  = 8'(src);
            f[23:8] = 16'(seq_ctr[src]);
            f[FW]   = (j == len - 1);
            seq_ctr[src]++;
            sq[src].push_back(f);
            tot_flits++;
        end
    endtask

    // retire accepted flits, then present the next one; a presented flit is held until accepted
    task automatic drive_sources(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) begin
            if (a[i] && sq[i].size() > 0) void'(sq[i].pop_front());
            if (!req_valid[i] || a[i]) begin
                if (sq[i].size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = sq[i][0][FW];
                    req_flit[i]  = sq[i][0][FW-1:0];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic cyc();
        logic [N-1:0] a;
        @(negedge clk);
        a = req_ready & req_valid;
        acc_tot += $countones(a);
        @(posedge clk);
        #1;
        drive_sources(a);
        if (rdy_mode) out_ready = ($urandom_range(9) < 7);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            sq[i].delete();
            seq_ctr[i] = 1;
        end
        req_valid = '0; req_last = '0; req_flit = '0;
        gap_en = 0; rdy_mode = 0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(2);
        seen.delete(); seen_cyc.delete();
        busy_n = 0; acc_tot = 0; tot_flits = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [23:0] e3 [4];

    initial begin
        // T1: single flit, ready in the same cycle, on the output one cycle later
        do_reset();
        sq[0].push_back({1'b1, 256'hA5});
        drive_sources('0);
        #2;
        chk("t1_ready_c0", req_ready, 3'b001);
        cyc();
        #2;
        chk("t1_valid_c1", out_valid, 1);
        chk("t1_flit_c1", out_flit, 256'hA5);
        chk("t1_last_c1", out_last, 1);
        run(3);

        // T2: three sources with back-to-back single-flit packets
        do_reset();
        for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) add_pkt(s, 1);
        drive_sources('0);
        run(12);
        chk("t2_count", seen.size(), 6);
        for (int i = 0; i < seen.size() && i < 6; i++) chk("t2_order", seen[i][7:0], i % 3);
        if (seen.size() >= 6) chk("t2_rate", seen_cyc[5] - seen_cyc[0], 5);

        // T3: src1 holds the port for its whole 3-flit packet while src0 waits
        do_reset();
        add_pkt(1, 3);
        drive_sources('0);
        cyc();
        add_pkt(0, 1);
        drive_sources('0);
        run(10);
        e3 = '{{16'd1, 8'd1}, {16'd2, 8'd1}, {16'd3, 8'd1}, {16'd1, 8'd0}};
        chk("t3_count", seen.size(), 4);
        for (int i = 0; i < seen.size() && i < 4; i++) chk("t3_order", seen[i], e3[i]);
        chk("t3_busy_cycles", busy_n, 2);

        // T4: router stalled, skid fills with two flits then backpressures
        do_reset();
        out_ready = 1'b0;
        add_pkt(2, 6);
        drive_sources('0);
        run(5);
        #2;
        chk("t4_accepted", acc_tot, 2);
        chk("t4_ready_full", req_ready, 0);
        chk("t4_head_seq", out_flit[23:0], {16'd1, 8'd2});
        out_ready = 1'b1;
        run(12);
        chk("t4_count", seen.size(), 6);
        for (int i = 0; i < seen.size() && i < 6; i++) chk("t4_order", seen[i], {16'(i + 1), 8'd2});

        // T5: reset in the middle of a 4-flit packet
        do_reset();
        add_pkt(0, 4);
        drive_sources('0);
        for (int k = 0; k < 10 && acc_tot < 2; k++) cyc();
        chk("t5_pre_busy", lock_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_valid_rst", out_valid, 0);
        chk("t5_busy_rst", lock_busy, 0);
        do_reset();
        add_pkt(1, 1);
        drive_sources('0);
        run(6);
        chk("t5_count", seen.size(), 1);
        if (seen.size() > 0) chk("t5_first", seen[0], {16'd1, 8'd1});

`ifdef DNOC_ARB_STAT_EN
        // T6: per-source packet counters and clear-beats-increment
        do_reset();
        for (int i = 0; i < 4; i++) add_pkt(0, 1);
        for (int i = 0; i < 2; i++) add_pkt(1, 1);
        drive_sources('0);
        run(12);
        chk("t6_cnt", pkt_cnt, {16'd0, 16'd2, 16'd4});
        add_pkt(0, 1);
        drive_sources('0);
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        #2;
        chk("t6_clr", pkt_cnt[0], 0);
        run(3);
`endif

        // random traffic: random packet lengths, source gaps and router backpressure
        do_reset();
        gap_en = 1;
        rdy_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) add_pkt($urandom_range(N - 1), $urandom_range(4, 1));
            cyc();
        end
        rdy_mode = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 2000 && (sq[0].size() + sq[1].size() + sq[2].size() > 0 || out_valid); c++) cyc();
        run(3);
        chk("rand_all_delivered", seen.size(), tot_flits);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
